gather_switch_allocator: RTL and testbench

GATHER_SWITCH_ALLOCATOR -- requirements
Module: gather_switch_allocator

---
 rtl/gather_switch_allocator.sv | 118 +++++++++++
 tb/tb_gather_switch_allocator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gather_switch_allocator.sv
// rtl/gather_switch_allocator.sv - per-output round-robin packet-locking switch allocator for a 5-port router
module gather_switch_allocator (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req_vc0,
  input  logic [4:0] req_vc1,
  input  logic [4:0] req_vc2,
  input  logic [4:0] req_vc3,
  input  logic [4:0] req_vc4,
  input  logic [4:0] valid_in,
  input  logic [4:0] head_in,
  input  logic [4:0] tail_in,
  input  logic [4:0] ready_in,
  output logic [4:0] selVCfromVC0,
  output logic [4:0] selVCfromVC1,
  output logic [4:0] selVCfromVC2,
  output logic [4:0] selVCfromVC3,
  output logic [4:0] selVCfromVC4,
  output logic [4:0] out_busy
);

  // sel_q[o] is the one-hot owner of output o (zero when FREE); it is both
  // the lock state and the registered crossbar select.
  logic [4:0][4:0] sel_q, sel_d;
  logic [4:0][2:0] rr_q, rr_d;
  logic [4:0][4:0] req;
  logic [4:0][4:0] req_lo;
  logic [4:0][4:0] cand;
  logic [4:0][4:0] sel_in;
  logic [4:0]      in_busy;
  logic            found;
  logic [3:0]      sum;
  logic [2:0]      idx;

  assign req[0] = req_vc0;
  assign req[1] = req_vc1;
  assign req[2] = req_vc2;
  assign req[3] = req_vc3;
  assign req[4] = req_vc4;

  // Keep only the lowest request bit, mark inputs that already own an output, build candidate sets.
  always_comb begin
    in_busy = '0;
    req_lo  = '0;
    cand    = '0;
    for (int i = 0; i < 5; i++) begin
      req_lo[i] = req[i] & (~req[i] + 5'd1);
    end
    for (int o = 0; o < 5; o++) begin
      in_busy = in_busy | sel_q[o];
    end
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        cand[o][i] = valid_in[i] & head_in[i] & req_lo[i][o] & ~in_busy[i];
      end
    end
  end

  // Per output: release on tail fire when locked, otherwise round-robin grant from rr_q.
  always_comb begin
    sel_d = sel_q;
    rr_d  = rr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int o = 0; o < 5; o++) begin
      if (|sel_q[o]) begin
        if (ready_in[o] && (|(sel_q[o] & valid_in & tail_in))) begin
          sel_d[o] = '0;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          sum = {1'b0, rr_q[o]} + 4'(k);
          if (sum >= 4'd5) begin
            sum = sum - 4'd5;
          end
          idx = sum[2:0];
          if (!found && cand[o][idx]) begin
            found    = 1'b1;
            sel_d[o] = 5'b00001 << idx;
            rr_d[o]  = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          end
        end
      end
    end
  end

  // Lock/select and round-robin pointer registers; reset frees every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      rr_q  <= '0;
    end else begin
      sel_q <= sel_d;
      rr_q  <= rr_d;
    end
  end

  // Transpose the per-output owner vectors into per-input select vectors.
  always_comb begin
    sel_in   = '0;
    out_busy = '0;
    for (int o = 0; o < 5; o++) begin
      out_busy[o] = |sel_q[o];
      for (int i = 0; i < 5; i++) begin
        sel_in[i][o] = sel_q[o][i];
      end
    end
  end

  assign selVCfromVC0 = sel_in[0];
  assign selVCfromVC1 = sel_in[1];
  assign selVCfromVC2 = sel_in[2];
  assign selVCfromVC3 = sel_in[3];
  assign selVCfromVC4 = sel_in[4];

endmodule

// File: tb/tb_gather_switch_allocator.sv
// tb/tb_gather_switch_allocator.sv - randomized and directed checks of gather_switch_allocator against an owner-table model
module tb_gather_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req [5];
  logic [4:0] valid_in, head_in, tail_in, ready_in;
  logic [4:0] sel [5];
  logic [4:0] out_busy;

  int n_checks = 0;
  int n_err    = 0;

  // model: owner[o] = owning input or -1 when free; ptr[o] = round-robin start
  int owner [5];
  int ptr   [5];

  always #5 clk = ~clk;

  gather_switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_vc0(req[0]), .req_vc1(req[1]), .req_vc2(req[2]), .req_vc3(req[3]), .req_vc4(req[4]),
    .valid_in(valid_in), .head_in(head_in), .tail_in(tail_in), .ready_in(ready_in),
    .selVCfromVC0(sel[0]), .selVCfromVC1(sel[1]), .selVCfromVC2(sel[2]),
    .selVCfromVC3(sel[3]), .selVCfromVC4(sel[4]),
    .out_busy(out_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_port(input logic [4:0] r);
    for (int b = 0; b < 5; b++) if (r[b]) return b;
    return -1;
  endfunction

  task automatic idle();
    rst      = 1'b0;
    valid_in = '0;
    head_in  = '0;
    tail_in  = '0;
    ready_in = '0;
    for (int i = 0; i < 5; i++) req[i] = '0;
  endtask

  // Advance one clock: derive the model's next state from current inputs, then compare all outputs.
  task automatic step();
    int  nown [5];
    int  nptr [5];
    bit  ibusy [5];
    logic [4:0] exp_sel;
    logic [4:0] exp_busy;
    for (int o = 0; o < 5; o++) begin
      nown[o] = owner[o];
      nptr[o] = ptr[o];
    end
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        nown[o] = -1;
        nptr[o] = 0;
      end
    end else begin
      for (int i = 0; i < 5; i++) ibusy[i] = 0;
      for (int o = 0; o < 5; o++) if (owner[o] >= 0) ibusy[owner[o]] = 1;
      for (int o = 0; o < 5; o++) begin
        if (owner[o] >= 0) begin
          if (valid_in[owner[o]] && ready_in[o] && tail_in[owner[o]]) nown[o] = -1;
        end else begin
          for (int k = 0; k < 5; k++) begin
            int i;
            i = (ptr[o] + k) % 5;
            if (valid_in[i] && head_in[i] && !ibusy[i] && lowest_port(req[i]) == o) begin
              nown[o] = i;
              nptr[o] = (i + 1) % 5;
              break;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int o = 0; o < 5; o++) begin
      owner[o] = nown[o];
      ptr[o]   = nptr[o];
    end
    exp_busy = '0;
    for (int o = 0; o < 5; o++) if (owner[o] >= 0) exp_busy[o] = 1'b1;
    check("out_busy", 32'(out_busy), 32'(exp_busy));
    for (int i = 0; i < 5; i++) begin
      exp_sel = '0;
      for (int o = 0; o < 5; o++) if (owner[o] == i) exp_sel[o] = 1'b1;
      check($sformatf("sel%0d", i), 32'(sel[i]), 32'(exp_sel));
    end
  endtask

  initial begin
    for (int o = 0; o < 5; o++) begin
      owner[o] = -1;
      ptr[o]   = 0;
    end
    idle();
    rst = 1'b1;
    step();
    check("reset_busy", 32'(out_busy), 32'h0);
    idle();

    // single grant: in2 -> out1
    valid_in[2] = 1'b1; head_in[2] = 1'b1; req[2] = 5'b00010;
    step();
    check("s1_sel2", 32'(sel[2]), 32'h02);
    check("s1_busy", 32'(out_busy), 32'h02);
    idle();
    step();
    check("s1_hold", 32'(sel[2]), 32'h02);
    valid_in[2] = 1'b1; tail_in[2] = 1'b1; ready_in[1] = 1'b1;
    step();
    check("s1_release", 32'(out_busy), 32'h0);
    idle();

    // contention on out4 from in0, in1, in3, one-flit bodies with tail
    for (int n = 0; n < 3; n++) begin
      int w;
      w = (n == 2) ? 3 : n;
      idle();
      for (int i = 0; i < 5; i++) if (i == 0 || i == 1 || i == 3) begin
        valid_in[i] = 1'b1; head_in[i] = 1'b1; req[i] = 5'b10000;
      end
      if (n == 1) begin valid_in[0] = 1'b0; head_in[0] = 1'b0; end
      if (n == 2) begin valid_in[0] = 1'b0; head_in[0] = 1'b0; valid_in[1] = 1'b0; head_in[1] = 1'b0; end
      step();
      check($sformatf("s2_grant%0d", n), 32'(sel[w]), 32'h10);
      idle();
      valid_in[w] = 1'b1; tail_in[w] = 1'b1; ready_in[4] = 1'b1;
      step();
      idle();
      step();
    end
    check("s2_ptr4", 32'(ptr[4]), 32'd4);

    // parallel grants plus a third lock, then reset mid-packet
    valid_in[0] = 1'b1; head_in[0] = 1'b1; req[0] = 5'b01000;
    valid_in[1] = 1'b1; head_in[1] = 1'b1; req[1] = 5'b00100;
    step();
    check("s4_busy", 32'(out_busy), 32'h0c);
    idle();
    valid_in[2] = 1'b1; head_in[2] = 1'b1; req[2] = 5'b00001;
    step();
    check("s6_three_locked", 32'(out_busy), 32'h0d);
    idle();
    rst = 1'b1;
    step();
    check("s6_reset_busy", 32'(out_busy), 32'h0);
    idle();
    valid_in[3] = 1'b1; head_in[3] = 1'b1; req[3] = 5'b00001;
    step();
    check("s6_regrant", 32'(sel[3]), 32'h01);
    idle();

    // randomized traffic against the owner-table model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 5; i++) begin
        int r;
        valid_in[i] = ($urandom_range(0, 9) < 7);
        head_in[i]  = ($urandom_range(0, 1) == 1);
        tail_in[i]  = ($urandom_range(0, 9) < 3);
        ready_in[i] = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 9);
        if (r == 0) req[i] = '0;
        else if (r == 1) req[i] = 5'($urandom_range(0, 31));
        else req[i] = 5'b00001 << $urandom_range(0, 4);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
